// File: rtl/axi_alu_core_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_alu_core_if
// Description : Valid/ready bundle for the ALU core. Carries the 8-bit input
//               byte stream (s_*) and the 16-bit result channel (m_*).
// Ports       : none (signal bundle only)
//   s_data   [7:0]  byte from upstream FIFO
//   s_valid         byte valid
//   s_ready         core accepts a byte
//   m_result [15:0] ALU result
//   m_zero          result is zero
//   m_err           illegal opcode in the frame
//   m_valid         result valid
//   m_ready         downstream accepts the result
// Modports    : slave  - the ALU core view
//               master - the surrounding environment (FIFO + result sink)
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_alu_core_if;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] m_result;
  logic        m_zero;
  logic        m_err;
  logic        m_valid;
  logic        m_ready;

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_result, m_zero, m_err, m_valid
  );

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_result, m_zero, m_err, m_valid
  );
endinterface
`default_nettype wire

// File: rtl/axi_alu_core.sv
`default_nettype none
// ============================================================================
// Module      : axi_alu_core
// Description : Assembles three-byte frames (opcode, A, B) from a valid/ready
//               byte stream, evaluates them in a registered ALU and presents
//               the 16-bit result on a valid/ready result channel.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous, active-low reset
//               bus   - axi_alu_core_if.slave (s_* byte input, m_* result)
// Options     : ALU_MUL_EN - when defined, opcode 0x07 is a legal 8x8
//               unsigned multiply; otherwise 0x07 is an illegal opcode.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_alu_core (
  input  wire logic         clk,
  input  wire logic         reset,
  axi_alu_core_if.slave     bus
);

  typedef enum logic [2:0] {
    GET_OP = 3'd0,
    GET_A  = 3'd1,
    GET_B  = 3'd2,
    EXEC   = 3'd3,
    OUT    = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [7:0]  r_op;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic        r_s_ready;
  logic [15:0] r_m_result;
  logic        r_m_zero;
  logic        r_m_err;
  logic        r_m_valid;

  logic        w_accept;
  logic        w_out_hs;
  logic        w_s_ready_next;
  logic [8:0]  w_sum;
  logic [8:0]  w_diff;
  logic [7:0]  w_shl;
  logic [7:0]  w_shr;
  logic [15:0] w_alu_res;
  logic        w_alu_err;

  // Byte acceptance uses the registered ready so no input reaches an output
  // combinationally.
  assign w_accept = bus.s_valid && r_s_ready;
  assign w_out_hs = r_m_valid && bus.m_ready;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      GET_OP:  if (w_accept) w_state_next = GET_A;
      GET_A:   if (w_accept) w_state_next = GET_B;
      GET_B:   if (w_accept) w_state_next = EXEC;
      EXEC:    w_state_next = OUT;
      OUT:     if (w_out_hs) w_state_next = GET_OP;
      default: w_state_next = GET_OP;
    endcase
  end

  // Ready is registered from the next state, so it is already low in the
  // cycle after B is taken and already high in the cycle after the result
  // handshake.
  assign w_s_ready_next = (w_state_next == GET_OP) ||
                          (w_state_next == GET_A)  ||
                          (w_state_next == GET_B);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= GET_OP;
      r_s_ready <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_s_ready <= w_s_ready_next;
    end
  end

  // --------------------------------------------------------------------------
  // ALU (evaluated from the captured frame during EXEC)
  // --------------------------------------------------------------------------
  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  // 9-bit subtract: bit 8 is the borrow when A < B.
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};
  assign w_shl  = r_a << r_b[2:0];
  assign w_shr  = r_a >> r_b[2:0];

  always_comb begin
    w_alu_res = 16'h0000;
    w_alu_err = 1'b0;
    case (r_op)
      8'h00:   w_alu_res = {7'b0, w_sum};
      8'h01:   w_alu_res = {7'b0, w_diff};
      8'h02:   w_alu_res = {8'b0, r_a & r_b};
      8'h03:   w_alu_res = {8'b0, r_a | r_b};
      8'h04:   w_alu_res = {8'b0, r_a ^ r_b};
      8'h05:   w_alu_res = {8'b0, w_shl};
      8'h06:   w_alu_res = {8'b0, w_shr};
`ifdef ALU_MUL_EN
      8'h07:   w_alu_res = {8'b0, r_a} * {8'b0, r_b};
`endif
      default: begin
        w_alu_res = 16'h0000;
        w_alu_err = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Frame capture and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op       <= 8'h00;
      r_a        <= 8'h00;
      r_b        <= 8'h00;
      r_m_result <= 16'h0000;
      r_m_zero   <= 1'b0;
      r_m_err    <= 1'b0;
      r_m_valid  <= 1'b0;
    end else begin
      if (w_accept) begin
        case (r_state)
          GET_OP:  r_op <= bus.s_data;
          GET_A:   r_a  <= bus.s_data;
          GET_B:   r_b  <= bus.s_data;
          default: ;
        endcase
      end
      if (r_state == EXEC) begin
        r_m_result <= w_alu_res;
        r_m_zero   <= (w_alu_res == 16'h0000);
        r_m_err    <= w_alu_err;
        r_m_valid  <= 1'b1;
      end else if (r_state == OUT && w_out_hs) begin
        // Result fields keep their last value; only valid drops.
        r_m_valid  <= 1'b0;
      end
    end
  end

  assign bus.s_ready  = r_s_ready;
  assign bus.m_result = r_m_result;
  assign bus.m_zero   = r_m_zero;
  assign bus.m_err    = r_m_err;
  assign bus.m_valid  = r_m_valid;

endmodule
`default_nettype wire

// File: tb/tb_axi_alu_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_alu_core
// Description : Self-checking bench for axi_alu_core. Expected results are
//               queued when a frame is sent and compared when the result
//               handshake happens. Honours ALU_MUL_EN for opcode 0x07.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_alu_core;

  logic clk;
  logic reset;
  axi_alu_core_if bus ();

  axi_alu_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [17:0] sb[$];   // {result[15:0], zero, err}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent reference model using integer arithmetic.
  function automatic logic [17:0] model(input logic [7:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    int ia;
    int ib;
    int r;
    logic err;
    ia  = int'(a);
    ib  = int'(b);
    r   = 0;
    err = 1'b0;
    case (op)
      8'h00: r = ia + ib;
      8'h01: r = (ia >= ib) ? (ia - ib) : (ia - ib + 512);
      8'h02: r = int'(a & b);
      8'h03: r = int'(a | b);
      8'h04: r = int'(a ^ b);
      8'h05: r = (ia * (1 << (ib % 8))) % 256;
      8'h06: r = ia / (1 << (ib % 8));
`ifdef ALU_MUL_EN
      8'h07: r = ia * ib;
`endif
      default: begin r = 0; err = 1'b1; end
    endcase
    return {r[15:0], (r == 0), err};
  endfunction

  // Result monitor: a beat is taken on the rising edge following a negedge
  // where valid and ready are both high.
  always @(negedge clk) begin
    if (reset && bus.m_valid && bus.m_ready) begin
      logic [17:0] exp;
      if (sb.size() == 0) begin
        chk("unexpected_beat", {14'b0, bus.m_result, bus.m_zero, bus.m_err}, 32'hFFFF_FFFF);
      end else begin
        exp = sb.pop_front();
        chk("beat_result", {16'b0, bus.m_result}, {16'b0, exp[17:2]});
        chk("beat_zero",   {31'b0, bus.m_zero},   {31'b0, exp[1]});
        chk("beat_err",    {31'b0, bus.m_err},    {31'b0, exp[0]});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    bus.s_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.s_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    n_checks++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL send_timeout: observed s_ready=0 expected s_ready=1 for byte %0h", b);
    end
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] a,
                            input logic [7:0] b, input int gap);
    sb.push_back(model(op, a, b));
    send_byte(op, gap);
    send_byte(a, gap);
    send_byte(b, gap);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !bus.m_valid) done = 1'b1;
    end
    n_checks++;
    assert (done) else begin
      n_fail++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    reset       = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_result", {16'b0, bus.m_result}, 32'h0);
    chk("rst_zero",   {31'b0, bus.m_zero},   32'h0);
    chk("rst_err",    {31'b0, bus.m_err},    32'h0);
    chk("rst_valid",  {31'b0, bus.m_valid},  32'h0);
    chk("rst_sready", {31'b0, bus.s_ready},  32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rel_sready_pre", {31'b0, bus.s_ready}, 32'h0);
    @(negedge clk);
    chk("rel_sready_post", {31'b0, bus.s_ready}, 32'h1);
    @(posedge clk); #1;

    // Reset mid-frame discards the partial frame
    bus.m_ready = 1'b1;
    send_byte(8'h00, 0);
    send_byte(8'h12, 0);
    reset = 1'b0;
    #1;
    chk("midrst_sready", {31'b0, bus.s_ready}, 32'h0);
    chk("midrst_valid",  {31'b0, bus.m_valid}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    send_frame(8'h00, 8'h01, 8'h02, 0);
    wait_drain();

    // ADD with carry plus latency
    send_frame(8'h00, 8'hFF, 8'h01, 0);
    @(negedge clk);
    chk("lat_exec_valid",  {31'b0, bus.m_valid}, 32'h0);
    chk("lat_exec_sready", {31'b0, bus.s_ready}, 32'h0);
    @(negedge clk);
    chk("lat_out_valid",   {31'b0, bus.m_valid}, 32'h1);
    @(negedge clk);
    chk("lat_done_valid",  {31'b0, bus.m_valid}, 32'h0);
    chk("lat_done_sready", {31'b0, bus.s_ready}, 32'h1);
    @(posedge clk); #1;
    wait_drain();

    // SUB zero and borrow
    send_frame(8'h01, 8'h05, 8'h05, 0);
    send_frame(8'h01, 8'h03, 8'h05, 0);
    wait_drain();

    // Other logic ops
    send_frame(8'h02, 8'hF0, 8'h3C, 0);
    send_frame(8'h03, 8'hA0, 8'h05, 1);
    send_frame(8'h06, 8'h81, 8'h0B, 0);
    wait_drain();

    // Backpressure on SHL
    bus.m_ready = 1'b0;
    send_frame(8'h05, 8'h81, 8'h03, 0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (bus.m_valid) seen = 1'b1;
      end
      chk("bp_valid_seen", {31'b0, seen}, 32'h1);
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_result", {16'b0, bus.m_result}, 32'h0008);
      chk("bp_hold_valid",  {31'b0, bus.m_valid},  32'h1);
      chk("bp_hold_sready", {31'b0, bus.s_ready},  32'h0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    @(negedge clk);
    chk("bp_rel_valid",  {31'b0, bus.m_valid}, 32'h0);
    chk("bp_rel_sready", {31'b0, bus.s_ready}, 32'h1);
    chk("bp_keep_result", {16'b0, bus.m_result}, 32'h0008);
    @(posedge clk); #1;
    bus.m_ready = 1'b1;

    // Multiply (legal or illegal depending on build)
    send_frame(8'h07, 8'hFF, 8'hFF, 0);
    wait_drain();

    // Illegal opcode with stalled input, then XOR
    send_frame(8'h2A, 8'h10, 8'h20, 3);
    send_frame(8'h04, 8'hF0, 8'h0F, 0);
    wait_drain();

    chk("sb_empty", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
